seq_mult16: RTL and testbench

- Unsigned 16x16 -> 32-bit sequential shift-and-add multiplier.
- Sits directly downstream of the 16-bit carry-lookahead adder: each cycle it instantiates the adder and consumes its sum and carry-out.
- Trades throughput for area: one multiply takes WIDTH iterations through a single adder.
- Uses a valid/ready handshake on both the operand side and the result side.

---
 rtl/seq_mult16.sv | 173 +++++++++++++++++
 tb/tb_seq_mult16.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult16.sv
// Purpose : unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier over one CLA adder.
// Latency : operands accepted at edge N -> out_valid after edge N+WIDTH; issue interval WIDTH+2.
// Backpr. : in_ready only in IDLE; result held in DONE until out_ready, no accept-on-consume bypass.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake, a = multiplicand, b = multiplier
//   out_valid/out_ready   result handshake, product = a*b (last result outside DONE)
//   busy                  high while iterating

// 4-bit carry-lookahead slice, returns {carry_out, sum}.
module seq_mult16_cla #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   function automatic logic [4:0] cla4(input logic [3:0] fx, input logic [3:0] fy,
                                       input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic       c1, c2, c3, c4;
      g  = fx & fy;
      p  = fx ^ fy;
      c1 = g[0] | (p[0] & ci);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c4, p ^ {c3, c2, c1, ci}};
   endfunction

   // Slices are chained carry-out to carry-in; each slice resolves its own
   // four carries in lookahead form.
   always_comb begin
      logic       c;
      logic [4:0] r;
      s = '0;
      c = cin;
      for (int i = 0; i < WIDTH / 4; i++) begin
         r          = cla4(x[4*i +: 4], y[4*i +: 4], c);
         s[4*i +: 4] = r[3:0];
         c          = r[4];
      end
      co = c;
   end

endmodule

module seq_mult16 #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]   m;
   logic [WIDTH-1:0]   h;
   logic [WIDTH-1:0]   l;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] prod_q;

   logic               load;
   logic               step;
   logic               last_iter;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               carry;
   logic [2*WIDTH-1:0] shifted;

   // Partial product accumulates in H; the multiplier bit under test is L[0].
   assign addend = l[0] ? m : '0;

   seq_mult16_cla #(.WIDTH(WIDTH)) u_cla (
      .x   (h),
      .y   (addend),
      .cin (1'b0),
      .s   (sum),
      .co  (carry)
   );

   // Carry lands in the top bit of H; L[0] has been consumed and drops out.
   assign shifted   = {carry, sum, l[WIDTH-1:1]};
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m      <= '0;
         h      <= '0;
         l      <= '0;
         cnt    <= '0;
         prod_q <= '0;
      end else if (load) begin
         m   <= a;
         h   <= '0;
         l   <= b;
         cnt <= '0;
      end else if (step) begin
         {h, l} <= shifted;
         cnt    <= cnt + CNT_W'(1);
         // Result register only moves on the final iteration, so the port
         // never shows partial products and keeps the last result afterwards.
         if (last_iter) begin
            prod_q <= shifted;
         end
      end
   end

   assign product = prod_q;

endmodule

// File: tb/tb_seq_mult16.sv
module tb_seq_mult16;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          in_ready;
   logic          out_valid;
   logic          busy;
   logic [2*W-1:0] product;

   int checks = 0;
   int failures = 0;

   seq_mult16 #(.WIDTH(W), .CNT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, so they are stable
   // at both the following falling edge and the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
   mphase_t        mph = M_IDLE;
   int             run_left = 0;
   logic [2*W-1:0] m_res = '0;
   logic [2*W-1:0] m_prod = '0;
   bit             armed = 1'b0;
   logic [2*W-1:0] sbq[$];
   int             issued = 0;
   int             retired = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         mph    = M_IDLE;
         m_prod = '0;
         sbq.delete();
         armed  = 1'b1;
      end else begin
         case (mph)
            M_IDLE: if (in_valid) begin
               m_res    = 32'(a) * 32'(b);
               run_left = W;
               mph      = M_RUN;
               sbq.push_back(m_res);
               issued++;
            end
            M_RUN: begin
               run_left--;
               if (run_left == 0) begin
                  mph    = M_DONE;
                  m_prod = m_res;
               end
            end
            M_DONE: if (out_ready) mph = M_IDLE;
            default: mph = M_IDLE;
         endcase
      end
   end

   // Per-cycle compare against the model plus result scoreboard.
   always @(negedge clk) begin
      if (armed) begin
         check("ctrl{in_ready,busy,out_valid}", {in_ready, busy, out_valid},
               {mph == M_IDLE, mph == M_RUN, mph == M_DONE});
         check("product_vs_model", product, m_prod);
         if (out_valid && out_ready) begin
            check("result_pending", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
               check("sb_product", product, sbq.pop_front());
               retired++;
            end
         end
      end
   end

   // ---------------- directed operation ----------------
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                         input logic [2*W-1:0] req, input int hold, input bit junk,
                         input string nm);
      int guard = 0;
      int lat = 0;
      int bc = 0;
      while (!in_ready && guard < 200) begin
         tick;
         guard++;
      end
      check({nm, "_in_ready_idle"}, in_ready, 1);
      a        = ta;
      b        = tb_b;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      if (junk) begin
         in_valid = 1'b1;
         a        = ~ta;
         b        = 16'h1357;
      end
      check({nm, "_in_ready_drop"}, in_ready, 0);
      bc = int'(busy);
      while (!out_valid && lat < 100) begin
         tick;
         lat++;
         bc = bc + int'(busy);
      end
      check({nm, "_latency"}, lat, 16);
      check({nm, "_busy_cycles"}, bc, 16);
      check({nm, "_product"}, product, req);
      for (int i = 0; i < hold; i++) begin
         tick;
         check({nm, "_hold_valid"}, out_valid, 1);
         check({nm, "_hold_product"}, product, req);
         check({nm, "_hold_in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      check({nm, "_post_out_valid"}, out_valid, 0);
      check({nm, "_post_in_ready"}, in_ready, 1);
      check({nm, "_post_product"}, product, req);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rst_n = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      check("reset_in_ready", in_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_product", product, 0);

      run_op(16'd3,     16'd5,     32'h0000_000F, 0, 1'b0, "mul3x5");
      run_op(16'hFFFF,  16'hFFFF,  32'hFFFE_0001, 0, 1'b0, "max");
      run_op(16'h1234,  16'h0000,  32'h0000_0000, 0, 1'b0, "bzero");
      run_op(16'h0000,  16'hABCD,  32'h0000_0000, 0, 1'b0, "azero");
      run_op(16'h8000,  16'h0002,  32'h0001_0000, 5, 1'b1, "hold");

      // Reset in the middle of a run discards it.
      a        = 16'h00FF;
      b        = 16'h0101;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      repeat (7) tick;
      check("midrun_busy", busy, 1);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_product", product, 0);
      check("rst_in_ready", in_ready, 1);
      run_op(16'd7, 16'd9, 32'd63, 0, 1'b0, "mul7x9");

      // Random operands with random back-pressure.
      issued  = 0;
      retired = 0;
      guard   = 0;
      while (issued < 1000 && guard < 60000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = 16'($urandom);
         b         = 16'($urandom);
         out_ready = ($urandom_range(0, 1) != 0);
         tick;
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard     = 0;
      while (sbq.size() != 0 && guard < 200) begin
         tick;
         guard++;
      end
      out_ready = 1'b0;
      tick;
      check("rand_issued", issued, 1000);
      check("rand_retired", retired, 1000);
      check("rand_queue_empty", sbq.size(), 0);
      check("rand_end_in_ready", in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
